// File: rtl/coeff_loader16.sv
// Serial-to-parallel loader: assembles 16-beat coefficient frames and strobes them into the
// operand RAM in one cycle. Optional input reduction mod Q is enabled by COEFF_MOD_REDUCE_EN.
`timescale 1ns/1ps

module coeff_loader16 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 16,
    parameter int unsigned Q          = 12289
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_last,
    input  logic                         ntt_busy,
    output logic                         load,
    output logic [N*DATA_WIDTH-1:0]      dout_flat,
    output logic                         frame_err,
    output logic [7:0]                   frame_cnt
);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [3:0]            LAST_IDX = 4'(N - 1);
    localparam logic [DATA_WIDTH-1:0] Q_W      = DATA_WIDTH'(Q);

`ifdef COEFF_MOD_REDUCE_EN
    localparam bit REDUCE_EN = 1'b1;
`else
    localparam bit REDUCE_EN = 1'b0;
`endif

    logic [1:0]                     r_state;
    logic [3:0]                     r_idx;
    logic                           r_en;
    logic                           r_err;
    logic [7:0]                     r_cnt;
    logic [N-1:0][DATA_WIDTH-1:0]   r_mem;

    logic                           w_accept;
    logic                           w_at_end;
    logic [DATA_WIDTH-1:0]          w_wdata;

    // Single conditional subtract; inputs are assumed below 2Q.
    assign w_wdata  = (REDUCE_EN && (s_data >= Q_W)) ? (s_data - Q_W) : s_data;
    assign w_at_end = (r_idx == LAST_IDX);
    assign w_accept = s_valid && s_ready;

    // r_en holds s_ready low until the first edge after reset release.
    assign s_ready   = r_en && (r_state == ST_FILL);
    assign load      = (r_state == ST_LOAD);
    assign dout_flat = r_mem;
    assign frame_err = r_err;
    assign frame_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_idx   <= '0;
            r_en    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_mem   <= '0;
        end else begin
            r_en  <= 1'b1;
            r_err <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_at_end && s_last) begin
                            r_mem[r_idx] <= w_wdata;
                            r_state      <= ST_WAIT;
                        end else if (w_at_end || s_last) begin
                            // Misframed beat is dropped and the frame restarts.
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_mem[r_idx] <= w_wdata;
                            r_idx        <= r_idx + 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!ntt_busy) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= r_cnt + 8'd1;
                    r_idx   <= '0;
                    r_state <= ST_FILL;
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_loader16.sv
// Scoreboarded bench for coeff_loader16: directed frames plus randomized frames, busy and gaps.
`timescale 1ns/1ps

module tb_coeff_loader16;

    localparam int DW = 16;
    localparam int NC = 16;
    localparam int QM = 12289;

    typedef logic [NC-1:0][DW-1:0] frame_t;
    typedef struct {
        frame_t     data;
        logic [7:0] cnt;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic              s_last;
    logic              ntt_busy;
    logic              load;
    logic [NC*DW-1:0]  dout_flat;
    logic              frame_err;
    logic [7:0]        frame_cnt;

    coeff_loader16 #(.DATA_WIDTH(DW), .N(NC), .Q(QM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .ntt_busy  (ntt_busy),
        .load      (load),
        .dout_flat (dout_flat),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t   exp_q[$];
    int     err_pend;
    int     n_tests;
    int     n_fail;
    bit     rnd_busy;

    // Reference model state: words collected so far in the current frame and loads so far.
    int     m_idx;
    frame_t m_buf;
    int     m_cnt;

    function automatic logic [DW-1:0] ref_store(input logic [DW-1:0] w);
`ifdef COEFF_MOD_REDUCE_EN
        if (int'(w) >= QM) return DW'(int'(w) - QM);
`endif
        return w;
    endfunction

    task automatic check(input string name, input logic [NC*DW-1:0] got,
                         input logic [NC*DW-1:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input bit last);
        exp_t e;
        if (m_idx == NC - 1 && last) begin
            m_buf[NC-1] = ref_store(d);
            e.data = m_buf;
            e.cnt  = 8'(m_cnt);
            exp_q.push_back(e);
            m_cnt = (m_cnt + 1) % 256;
            m_idx = 0;
        end else if (last || m_idx == NC - 1) begin
            err_pend++;
            m_idx = 0;
        end else begin
            m_buf[m_idx] = ref_store(d);
            m_idx++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send(input logic [DW-1:0] d, input bit last);
        int t;
        t = 0;
        while (!s_ready && t < 200) begin
            if (rnd_busy) ntt_busy = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got s_ready=0 expected 1 within 200 cycles");
        end else begin
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last;
            model_accept(d, last);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_load(input string name, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load && n < 50);
        check(name, NC*DW'(n), NC*DW'(exp_n));
    endtask

    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (load) begin
                    check("load_back_to_back", NC*DW'(prev), '0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_load: got load=1 expected no load");
                    end else begin
                        e = exp_q.pop_front();
                        check("load_data", dout_flat, e.data);
                        check("load_cnt", NC*DW'(frame_cnt), NC*DW'(e.cnt));
                    end
                end
                if (frame_err) begin
                    n_tests++;
                    if (err_pend == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame_err: got frame_err=1 expected 0");
                    end else begin
                        err_pend--;
                    end
                end
                prev = load;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, dout_flat, '0);
        check({tag, "_load"}, NC*DW'(load), '0);
        check({tag, "_err"}, NC*DW'(frame_err), '0);
        check({tag, "_cnt"}, NC*DW'(frame_cnt), '0);
        check({tag, "_ready"}, NC*DW'(s_ready), '0);
    endtask

    task automatic drain_check(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_exp_empty"}, NC*DW'(exp_q.size()), '0);
        check({tag, "_err_seen"}, NC*DW'(err_pend), '0);
        check({tag, "_frame_cnt"}, NC*DW'(frame_cnt), NC*DW'(m_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;  n_fail = 0;  err_pend = 0;
        m_idx = 0;    m_cnt = 0;   m_buf = '0;  rnd_busy = 1'b0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; ntt_busy = 1'b0;
        fork
            monitor();
        join_none

        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_low_at_release", NC*DW'(s_ready), '0);
        @(negedge clk);
        check("ready_after_release", NC*DW'(s_ready), NC*DW'(1));

        // Ascending frame, no busy: load two cycles after the last beat.
        for (int k = 0; k < NC; k++) send(DW'(k), k == NC - 1);
        wait_load("latency_idle", 1);
        @(negedge clk);
        check("cnt_after_first", NC*DW'(frame_cnt), NC*DW'(1));

        // Busy held for five cycles after the last beat.
        for (int k = 0; k < NC; k++) begin
            if (k == NC - 1) ntt_busy = 1'b1;
            send(DW'(k + 100), k == NC - 1);
        end
        for (int i = 0; i < 5; i++) begin
            check("busy_no_load", NC*DW'(load), '0);
            check("busy_not_ready", NC*DW'(s_ready), '0);
            @(negedge clk);
        end
        ntt_busy = 1'b0;
        wait_load("latency_busy", 1);

        // Early s_last, then a clean frame.
        for (int k = 0; k < 8; k++) send(DW'(k + 7), k == 7);
        for (int k = 0; k < NC; k++) send(DW'($urandom_range(0, 2 * QM - 1)), k == NC - 1);
        drain_check("early_last");

        // Missing s_last, then a frame of 0xAAAA.
        for (int k = 0; k < NC; k++) send(DW'(k + 1), 1'b0);
        for (int k = 0; k < NC; k++) send(16'hAAAA, k == NC - 1);
        drain_check("no_last");

        // Words around the modulus boundary.
        send(16'd12289, 1'b0);
        send(16'd12290, 1'b0);
        send(16'd24577, 1'b0);
        send(16'd5, 1'b0);
        for (int k = 4; k < NC; k++) send(DW'(12284 + k), k == NC - 1);
        drain_check("modq");

        // Asynchronous reset mid-frame discards the partial frame.
        for (int k = 0; k < 9; k++) send(DW'(k + 50), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_idx = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NC; k++) send(DW'(k * 3), k == NC - 1);
        wait_load("latency_after_reset", 1);
        @(negedge clk);
        check("cnt_after_reset", NC*DW'(frame_cnt), NC*DW'(1));

        // Randomized frames, framing errors, gaps and busy.
        rnd_busy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int kind;
            int pos;
            kind = $urandom_range(0, 9);
            pos  = $urandom_range(0, NC - 2);
            for (int k = 0; k < NC; k++) begin
                bit last;
                if (kind == 0 && k > pos) break;
                last = (kind == 0) ? (k == pos) : (kind == 1) ? 1'b0 : (k == NC - 1);
                ntt_busy = ($urandom_range(0, 2) == 0);
                send(DW'($urandom_range(0, 2 * QM - 1)), last);
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end
        rnd_busy = 1'b0;
        ntt_busy = 1'b0;
        repeat (6) @(negedge clk);
        drain_check("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
